regfile_2w2r_sb: RTL

- Parametrised successor to the two-read / one-write MIPS register file.
- Two asynchronous read ports (A, B) and two write ports: WB0 for ALU writeback (higher priority) and WB1 for load writeback.
- Adds a per-register pending scoreboard: set at issue, cleared on writeback. The pipeline uses it to generate RAW-hazard stalls.
- Sits between decode (reads, scoreboard set) and writeback (writes).

---
 rtl/regfile_2w2r_sb.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_2w2r_sb.sv
// regfile_2w2r_sb
// ---------------------------------------------------------------------------
// Register file with two combinational read ports and two write ports, plus
// a per-register pending scoreboard for RAW-hazard stall generation.
//
// Write ports:
//   WB0 (ALU writeback) has priority over WB1 (load writeback). When both
//   write the same address in one cycle, the WB0 data is stored.
//
// Scoreboard:
//   A bit is set at issue (sb_set_in) and cleared by a write to that
//   register. If a set and a clear hit the same register, the set wins.
//   pending_cnt is a registered population count of the pending bits.
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   - reads see same-cycle write data (WB0 before WB1), and busy
//               is masked by a same-cycle write to the read address.
//   undefined - reads return the stored value only, and busy follows the
//               stored pending bit.
//
// Parameters:
//   DATA_W   register data width
//   ADDR_W   register address width (depth = 2**ADDR_W)
//   ZERO_REG 1 = register 0 reads as zero, ignores writes and sb sets
//
// Ports:
//   clk, reset                        rising-edge clock, async active-high reset
//   read_addrA/B, readdata_outA/B     combinational read ports
//   we0_in, write_reg0, write_data0   WB0 write port
//   we1_in, write_reg1, write_data1   WB1 write port
//   sb_set_in, sb_set_reg             mark a register pending
//   busyA, busyB                      read address pending and unresolved
//   pending_cnt                       number of pending registers
// ---------------------------------------------------------------------------
module regfile_2w2r_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_addrA,
    input  logic [ADDR_W-1:0] read_addrB,
    output logic [DATA_W-1:0] readdata_outA,
    output logic [DATA_W-1:0] readdata_outB,
    input  logic              we0_in,
    input  logic [ADDR_W-1:0] write_reg0,
    input  logic [DATA_W-1:0] write_data0,
    input  logic              we1_in,
    input  logic [ADDR_W-1:0] write_reg1,
    input  logic [DATA_W-1:0] write_data1,
    input  logic              sb_set_in,
    input  logic [ADDR_W-1:0] sb_set_reg,
    output logic              busyA,
    output logic              busyB,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam bit ZERO_HW = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;
    logic [ADDR_W:0]   cnt_nxt;

    // Write qualifiers after zero-register filtering.
    logic wr0_ok;
    logic wr1_ok;
    logic wr1_store;
    logic set_ok;

    always_comb begin
        wr0_ok    = we0_in && !(ZERO_HW && (write_reg0 == '0));
        wr1_ok    = we1_in && !(ZERO_HW && (write_reg1 == '0));
        // WB1 is dropped from the array when WB0 targets the same register;
        // it still counts as a writeback for scoreboard clearing.
        wr1_store = wr1_ok && !(wr0_ok && (write_reg1 == write_reg0));
        set_ok    = sb_set_in && !(ZERO_HW && (sb_set_reg == '0));
    end

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_ok) begin
                regs[write_reg0] <= write_data0;
            end
            if (wr1_store) begin
                regs[write_reg1] <= write_data1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard next state and population count
    // ------------------------------------------------------------------
    always_comb begin
        pending_nxt = pending;
        // Clears first so that a same-cycle set overrides them.
        if (wr0_ok) begin
            pending_nxt[write_reg0] = 1'b0;
        end
        if (wr1_ok) begin
            pending_nxt[write_reg1] = 1'b0;
        end
        if (set_ok) begin
            pending_nxt[sb_set_reg] = 1'b1;
        end

        cnt_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(pending_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic zero_a;
    logic zero_b;
    logic hit0_a;
    logic hit1_a;
    logic hit0_b;
    logic hit1_b;

    always_comb begin
        zero_a = ZERO_HW && (read_addrA == '0);
        zero_b = ZERO_HW && (read_addrB == '0);
        hit0_a = wr0_ok && (write_reg0 == read_addrA);
        hit1_a = wr1_ok && (write_reg1 == read_addrA);
        hit0_b = wr0_ok && (write_reg0 == read_addrB);
        hit1_b = wr1_ok && (write_reg1 == read_addrB);
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        readdata_outA = regs[read_addrA];
        if (zero_a) begin
            readdata_outA = '0;
        end else if (hit0_a) begin
            readdata_outA = write_data0;
        end else if (hit1_a) begin
            readdata_outA = write_data1;
        end
        busyA = !zero_a && pending[read_addrA] && !(hit0_a || hit1_a);
    end

    always_comb begin
        readdata_outB = regs[read_addrB];
        if (zero_b) begin
            readdata_outB = '0;
        end else if (hit0_b) begin
            readdata_outB = write_data0;
        end else if (hit1_b) begin
            readdata_outB = write_data1;
        end
        busyB = !zero_b && pending[read_addrB] && !(hit0_b || hit1_b);
    end
`else
    // Without bypass the same-cycle write hits are not used by the read path.
    logic unused_hits;
    assign unused_hits = hit0_a ^ hit1_a ^ hit0_b ^ hit1_b;

    always_comb begin
        readdata_outA = zero_a ? '0 : regs[read_addrA];
        busyA         = !zero_a && pending[read_addrA];
    end

    always_comb begin
        readdata_outB = zero_b ? '0 : regs[read_addrB];
        busyB         = !zero_b && pending[read_addrB];
    end
`endif

endmodule
